// File: rtl/dram_row_splitter.sv
// dram_row_splitter: cuts AXI4 INCR bursts that cross a 4 KB DRAM row into two row-aligned sub-bursts.
// Define DRAM_SPLIT_CNT_EN to add the saturating split_cnt output.
module dram_row_splitter (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ARID_S,
  input  logic [31:0] ARADDR_S,
  input  logic [3:0]  ARLEN_S,
  input  logic [2:0]  ARSIZE_S,
  input  logic [1:0]  ARBURST_S,
  input  logic        ARVALID_S,
  output logic        ARREADY_S,
  output logic [7:0]  RID_S,
  output logic [31:0] RDATA_S,
  output logic [1:0]  RRESP_S,
  output logic        RLAST_S,
  output logic        RVALID_S,
  input  logic        RREADY_S,
  input  logic [7:0]  AWID_S,
  input  logic [31:0] AWADDR_S,
  input  logic [3:0]  AWLEN_S,
  input  logic [2:0]  AWSIZE_S,
  input  logic [1:0]  AWBURST_S,
  input  logic        AWVALID_S,
  output logic        AWREADY_S,
  input  logic [31:0] WDATA_S,
  input  logic [3:0]  WSTRB_S,
  input  logic        WLAST_S,
  input  logic        WVALID_S,
  output logic        WREADY_S,
  output logic [7:0]  BID_S,
  output logic [1:0]  BRESP_S,
  output logic        BVALID_S,
  input  logic        BREADY_S,
  output logic [7:0]  ARID_M,
  output logic [31:0] ARADDR_M,
  output logic [3:0]  ARLEN_M,
  output logic [2:0]  ARSIZE_M,
  output logic [1:0]  ARBURST_M,
  output logic        ARVALID_M,
  input  logic        ARREADY_M,
  input  logic [7:0]  RID_M,
  input  logic [31:0] RDATA_M,
  input  logic [1:0]  RRESP_M,
  input  logic        RLAST_M,
  input  logic        RVALID_M,
  output logic        RREADY_M,
  output logic [7:0]  AWID_M,
  output logic [31:0] AWADDR_M,
  output logic [3:0]  AWLEN_M,
  output logic [2:0]  AWSIZE_M,
  output logic [1:0]  AWBURST_M,
  output logic        AWVALID_M,
  input  logic        AWREADY_M,
  output logic [31:0] WDATA_M,
  output logic [3:0]  WSTRB_M,
  output logic        WLAST_M,
  output logic        WVALID_M,
  input  logic        WREADY_M,
  input  logic [7:0]  BID_M,
  input  logic [1:0]  BRESP_M,
  input  logic        BVALID_M,
`ifdef DRAM_SPLIT_CNT_EN
  output logic [15:0] split_cnt,
`endif
  output logic        BREADY_M
);
  typedef enum logic [3:0] {IDLE, RA1, RD1, RA2, RD2, WA1, WD1, WB1, WA2, WD2, WB2} state_t;
  state_t state, state_next;
  logic [7:0]  id;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic        split;
  logic [31:0] cur_addr;
  logic [3:0]  cur_len;
  logic [19:0] a2_row;
  logic [3:0]  l2;
  logic [3:0]  cnt;
  logic [1:0]  resp1;
  logic        cap_rd, cap_wr, cap;
  logic [31:0] c_addr;
  logic [3:0]  c_len, c_l1;
  logic [1:0]  c_burst;
  logic        c_split;
  logic        rd_st, wd_st, final_b, r_last_hs, w_hs, seg1_b, seg2_load;
  logic        unused_inputs;
  assign unused_inputs = ^{WLAST_S, RID_M, BID_M};
  assign cap_rd  = state == IDLE && ARVALID_S;
  assign cap_wr  = state == IDLE && !ARVALID_S && AWVALID_S;
  assign cap     = cap_rd || cap_wr;
  assign c_addr  = cap_rd ? ARADDR_S : AWADDR_S;
  assign c_len   = cap_rd ? ARLEN_S : AWLEN_S;
  assign c_burst = cap_rd ? ARBURST_S : AWBURST_S;
  // Word index plus LEN reaching 1024 means the last beat lands in the next row.
  assign c_split = c_burst == 2'b01 && ({1'b0, c_addr[11:2]} + {7'd0, c_len}) > 11'd1023;
  // Low nibble of 1023 - word index; only those 4 bits survive into LEN.
  assign c_l1    = c_split ? 4'hF - c_addr[5:2] : c_len;
  assign rd_st     = state == RD1 || state == RD2;
  assign wd_st     = state == WD1 || state == WD2;
  assign seg1_b    = state == WB1 && split;
  assign final_b   = state == WB2 || (state == WB1 && !split);
  assign r_last_hs = rd_st && RVALID_M && RREADY_S && RLAST_M;
  assign w_hs      = wd_st && WVALID_S && WREADY_M;
  assign seg2_load = (state == RD1 && split && r_last_hs) || (seg1_b && BVALID_M);
  assign ARREADY_S = state == IDLE;
  assign AWREADY_S = state == IDLE && !ARVALID_S;
  assign ARID_M    = id;
  assign ARADDR_M  = cur_addr;
  assign ARLEN_M   = cur_len;
  assign ARSIZE_M  = size;
  assign ARBURST_M = burst;
  assign ARVALID_M = state == RA1 || state == RA2;
  assign AWID_M    = id;
  assign AWADDR_M  = cur_addr;
  assign AWLEN_M   = cur_len;
  assign AWSIZE_M  = size;
  assign AWBURST_M = burst;
  assign AWVALID_M = state == WA1 || state == WA2;
  assign RID_S     = id;
  assign RDATA_S   = RDATA_M;
  assign RRESP_S   = RRESP_M;
  assign RVALID_S  = rd_st && RVALID_M;
  assign RREADY_M  = rd_st && RREADY_S;
  assign RLAST_S   = rd_st && RLAST_M && (state == RD2 || !split);
  assign WDATA_M   = WDATA_S;
  assign WSTRB_M   = WSTRB_S;
  assign WVALID_M  = wd_st && WVALID_S;
  assign WREADY_S  = wd_st && WREADY_M;
  assign WLAST_M   = wd_st && cnt == cur_len;
  assign BID_S     = id;
  assign BVALID_S  = final_b && BVALID_M;
  assign BREADY_M  = seg1_b || (final_b && BREADY_S);
  assign BRESP_S   = resp1 > BRESP_M ? resp1 : BRESP_M;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = cap_rd ? RA1 : cap_wr ? WA1 : IDLE;
      RA1:     state_next = ARREADY_M ? RD1 : RA1;
      RD1:     state_next = r_last_hs ? (split ? RA2 : IDLE) : RD1;
      RA2:     state_next = ARREADY_M ? RD2 : RA2;
      RD2:     state_next = r_last_hs ? IDLE : RD2;
      WA1:     state_next = AWREADY_M ? WD1 : WA1;
      WD1:     state_next = w_hs && WLAST_M ? WB1 : WD1;
      WB1:     state_next = BVALID_M && BREADY_M ? (split ? WA2 : IDLE) : WB1;
      WA2:     state_next = AWREADY_M ? WD2 : WA2;
      WD2:     state_next = w_hs && WLAST_M ? WB2 : WD2;
      WB2:     state_next = BVALID_M && BREADY_S ? IDLE : WB2;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id       <= '0;
      size     <= '0;
      burst    <= '0;
      split    <= 1'b0;
      cur_addr <= '0;
      cur_len  <= '0;
      a2_row   <= '0;
      l2       <= '0;
      cnt      <= '0;
      resp1    <= 2'b00;
    end else begin
      if (cap) begin
        id       <= cap_rd ? ARID_S : AWID_S;
        size     <= cap_rd ? ARSIZE_S : AWSIZE_S;
        burst    <= c_burst;
        split    <= c_split;
        cur_addr <= c_addr;
        cur_len  <= c_l1;
        a2_row   <= c_addr[31:12] + 20'd1;
        l2       <= c_len - c_l1 - 4'd1;
        resp1    <= 2'b00;
      end
      if (seg2_load) begin
        cur_addr <= {a2_row, 12'h000};
        cur_len  <= l2;
      end
      if (seg1_b && BVALID_M) resp1 <= BRESP_M;
      if (w_hs) cnt <= WLAST_M ? 4'd0 : cnt + 4'd1;
    end
  end
`ifdef DRAM_SPLIT_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) split_cnt <= '0;
    else if (cap && c_split && split_cnt != 16'hFFFF) split_cnt <= split_cnt + 16'd1;
`endif
endmodule

// File: doc/dram_row_splitter.md
# dram_row_splitter

AXI4 burst splitter that sits directly upstream of the DRAM slave wrapper, between the bus slave port and the DRAM wrapper's AXI slave interface. Any INCR burst whose word range crosses a 4 KB DRAM row boundary (ADDR[11:2] wraps) is cut into two row-aligned sub-bursts. The DRAM wrapper therefore never walks its column address past the open row. Upstream sees one unmodified transaction: one contiguous R stream with a single RLAST, or one merged B response.

## Interface
- No parameters. Widths are fixed: ID 8, ADDR 32, LEN 4, SIZE 3, DATA 32, STRB 4.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S/ARVALID_S  in  8/32/4/3/2/1  upstream read address
- ARREADY_S  out  1  upstream read address ready
- RID_S/RDATA_S/RRESP_S/RLAST_S/RVALID_S  out  8/32/2/1/1  upstream read data
- RREADY_S  in  1
- AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S/AWVALID_S  in  8/32/4/3/2/1  upstream write address
- AWREADY_S  out  1
- WDATA_S/WSTRB_S/WLAST_S/WVALID_S  in  32/4/1/1; WREADY_S  out  1
- BID_S/BRESP_S/BVALID_S  out  8/2/1; BREADY_S  in  1
- AR*_M, AW*_M, WDATA_M/WSTRB_M/WLAST_M/WVALID_M, RREADY_M, BREADY_M  out  (same widths)  downstream master side to the DRAM wrapper
- ARREADY_M, AWREADY_M, WREADY_M, R*_M, B*_M  in  (same widths)  downstream responses

## Operation
- One transaction in flight at a time. States: IDLE, RA1, RD1, RA2, RD2, WA1, WD1, WB1, WA2, WD2, WB2.
- IDLE: ARREADY_S = AWREADY_S = 1.
  - A valid request is captured into registers: ID, ADDR, LEN, SIZE, BURST.
  - If ARVALID_S and AWVALID_S are both high, the read wins and AWREADY_S = 0 that cycle.
- Split decision, computed on capture:
  - w = ADDR[11:2]; e = {1'b0, w} + LEN, 11-bit.
  - split = BURST==INCR && e[10].
  - L1 = 10'd1023 − w, truncated to 4 bits.
  - A2 = {ADDR[31:12] + 1, 12'h000}.
  - L2 = LEN − L1 − 1.
  - When there is no split, L1 = LEN and the segment-2 states are skipped.
- RA1/RA2: ARVALID_M held high with ADDR/L1 (RA1) or A2/L2 (RA2) until ARREADY_M.
- RD1/RD2: the R channel is passed through combinationally.
  - RVALID_S = RVALID_M, RREADY_M = RREADY_S.
  - RDATA_S and RRESP_S pass through. RID_S = captured ID.
  - RLAST_S = RLAST_M only in the final segment. RLAST_M in RD1 of a split burst is masked.
  - An RLAST_M handshake moves RD1→RA2 (split) or →IDLE, and RD2→IDLE.
- WA1/WA2: AWVALID_M is driven the same way as ARVALID_M.
- WD1/WD2: W is passed through.
  - WVALID_M = WVALID_S, WREADY_S = WREADY_M.
  - A 4-bit beat counter resets per segment.
  - WLAST_M = (cnt == segment length). WLAST_S is ignored.
- WB1 of a split burst: BREADY_M = 1 and BVALID_S = 0. BRESP_M is stored in resp1.
- Final B state: BVALID_S = BVALID_M, BREADY_M = BREADY_S, BID_S = captured ID.
  - BRESP_S = the larger of resp1 and BRESP_M, so SLVERR/DECERR dominate OKAY.
  - resp1 is OKAY when there is no split.
- Reset: state goes to IDLE, all *VALID_M/*VALID_S outputs and counters go to 0, and resp1 = OKAY. A reset mid-burst abandons the transaction.

## Timing
- Reset values: every VALID/LAST output is 0, every downstream READY is 0, and ARREADY_S/AWREADY_S = 1 (IDLE).
- Address latency: an upstream AR/AW handshake in cycle N gives ARVALID_M/AWVALID_M in cycle N+1.
- Segment 2 address is issued the cycle after the last segment-1 R handshake or the WB1 handshake.
- Data and B paths add zero latency. Stalls propagate in the same cycle.
- After the final RLAST_S or BVALID_S handshake, the block is in IDLE the next cycle.
- Downstream addresses and lengths are registered and stable while VALID is high.

## Configuration
- DRAM_SPLIT_CNT_EN defined: adds output split_cnt (16 bit).
  - Increments once per split transaction, at capture.
  - Saturates at 16'hFFFF. Reset value 0.
- DRAM_SPLIT_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Read 0x2000_0010 LEN 3: one AR_M with the same address and LEN 3; four R beats upstream; RLAST_S on beat 4.
- Read 0x2000_0FF8 LEN 7:
  - AR1 = 0x2000_0FF8 LEN 1, then AR2 = 0x2000_1000 LEN 5.
  - Upstream sees 8 beats, RID constant, RLAST_S only on beat 8.
- Write 0x2000_1FFC LEN 3:
  - AW1 LEN 0 with WLAST_M on beat 1, then AW2 = 0x2000_2000 LEN 2 with WLAST_M on beat 3 of that segment.
  - Exactly one BVALID_S, BRESP_S = OKAY.
- Same write with BRESP_M = SLVERR on the first segment: BRESP_S = SLVERR.
- ARVALID_S and AWVALID_S high in the same IDLE cycle:
  - The read is accepted and AWREADY_S = 0.
  - The write is accepted in the first IDLE cycle after RLAST_S.
- rst pulsed during RD2 of a split read: next cycle RVALID_S = ARVALID_M = 0, ARREADY_S = 1, and split_cnt = 0 when enabled.
